fitness_evaluator: RTL and testbench

FITNESS_EVALUATOR -- requirements
Module: fitness_evaluator

---
 rtl/fitness_evaluator_pkg.sv | 17 +
 rtl/fitness_evaluator_settle.sv | 29 ++
 rtl/fitness_evaluator.sv | 107 ++++++++++
 tb/tb_fitness_evaluator.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fitness_evaluator_pkg.sv
// Shared types and sizes for the fitness evaluator.
// The evaluator runs a 4-input circuit through all 16 vectors.
package fitness_evaluator_pkg;

    localparam int N_VECTORS = 16;
    localparam int VEC_W     = 4;
    localparam int SCORE_W   = 5;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/fitness_evaluator_settle.sv
// Settle down-counter: loaded while a vector is driven,
// counts during SETTLE, flags the last settle cycle.
module settle_timer #(
    parameter int               CNT_W    = 4,
    parameter logic [CNT_W-1:0] LOAD_VAL = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    // Reload on DRIVE, count down while settling, stop at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = en && (cnt <= CNT_W'(1));

endmodule

// File: rtl/fitness_evaluator.sv
// Exhaustive truth-table checker for a 4-input circuit.
// Drives each vector, waits, samples, and scores matches.
module fitness_evaluator
    import fitness_evaluator_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int N_VECTORS     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N_VECTORS-1:0] target,
    output logic                 A,
    output logic                 B,
    output logic                 C,
    output logic                 D,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic [SCORE_W-1:0]   score,
    output logic [N_VECTORS-1:0] mismatch_mask,
    output logic                 pass
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [VEC_W-1:0] LAST_V = VEC_W'(N_VECTORS - 1);

    state_t               state;
    state_t               state_nx;
    logic [VEC_W-1:0]     v;
    logic [N_VECTORS-1:0] tgt;
    logic [SCORE_W-1:0]   score_nx;
    logic                 running;
    logic                 hit;
    logic                 last;
    logic                 settle_done;

    settle_timer #(
        .CNT_W    (4),
        .LOAD_VAL (SETTLE_LOAD)
    ) u_settle (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state == DRIVE),
        .en      (state == SETTLE),
        .expired (settle_done)
    );

    assign hit      = (dut_out == tgt[v]);
    assign last     = (v == LAST_V);
    assign score_nx = hit ? score + SCORE_W'(1) : score;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: one DRIVE, optional SETTLE, one SAMPLE per vector.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = DRIVE;
            DRIVE:   state_nx = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
            SETTLE:  if (settle_done) state_nx = SAMPLE;
            SAMPLE:  state_nx = last ? DONE : DRIVE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Run bookkeeping: latch target on accept, score each sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v             <= '0;
            tgt           <= '0;
            score         <= '0;
            mismatch_mask <= '0;
            pass          <= 1'b0;
        end else if (state == IDLE && start) begin
            v             <= '0;
            tgt           <= target;
            score         <= '0;
            mismatch_mask <= '0;
            pass          <= 1'b0;
        end else if (state == SAMPLE) begin
            score <= score_nx;
            if (!hit) mismatch_mask[v] <= 1'b1;
            if (last) begin
                pass <= (score_nx == SCORE_W'(N_VECTORS));
            end else begin
                v <= v + 1'b1;
            end
        end
    end

    assign running = (state == DRIVE) ||
                     (state == SETTLE) ||
                     (state == SAMPLE);
    assign busy = running;
    assign done = (state == DONE);
    assign {A, B, C, D} = running ? v : '0;

endmodule

// File: tb/tb_fitness_evaluator.sv
// Scoreboard bench: two evaluators (settle 1 and settle 0)
// each wrapped around a behavioural circuit model.
module tb_fitness_evaluator;

    localparam int S0 = 1;
    localparam int S1 = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start[2];
    logic [15:0] target[2];
    logic        a[2], b[2], c[2], d[2];
    logic        dut_out[2];
    logic        busy[2], done[2], pass[2];
    logic [4:0]  score[2];
    logic [15:0] mask[2];
    int          mode[2];

    typedef struct {
        int          inst;
        int          score;
        logic [15:0] mask;
        logic        pass;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc[2];
    int   done_cnt[2];
    logic busy_q[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fitness_evaluator #(.SETTLE_CYCLES(S0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .target(target[0]), .A(a[0]), .B(b[0]), .C(c[0]),
        .D(d[0]), .dut_out(dut_out[0]), .busy(busy[0]),
        .done(done[0]), .score(score[0]),
        .mismatch_mask(mask[0]), .pass(pass[0])
    );

    fitness_evaluator #(.SETTLE_CYCLES(S1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .target(target[1]), .A(a[1]), .B(b[1]), .C(c[1]),
        .D(d[1]), .dut_out(dut_out[1]), .busy(busy[1]),
        .done(done[1]), .score(score[1]),
        .mismatch_mask(mask[1]), .pass(pass[1])
    );

    // Circuit under evaluation: 0 = A&B, 1 = const 1, 2 = parity.
    function automatic logic model(int m, logic [3:0] x);
        case (m)
            0:       return x[3] & x[2];
            1:       return 1'b1;
            default: return ^x;
        endcase
    endfunction

    always_comb begin
        dut_out[0] = model(mode[0], {a[0], b[0], c[0], d[0]});
        dut_out[1] = model(mode[1], {a[1], b[1], c[1], d[1]});
    end

    task automatic chk(string tag, logic [31:0] got,
                       logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void push_exp(int k);
        exp_t e;
        e.inst  = k;
        e.score = 0;
        e.mask  = '0;
        for (int i = 0; i < 16; i++) begin
            if (model(mode[k], 4'(i)) == target[k][i])
                e.score++;
            else
                e.mask[i] = 1'b1;
        end
        e.pass = (e.score == 16);
        sbq.push_back(e);
    endfunction

    // Monitor: vector sequence, latency and scoreboard pops.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            automatic int sp;
            automatic logic [3:0] vec;
            automatic exp_t e;
            sp  = (k == 0) ? 2 + S0 : 2 + S1;
            vec = {a[k], b[k], c[k], d[k]};
            if (busy[k] && !busy_q[k]) acc[k] = cyc;
            if (busy[k])
                chk("vector", 32'(vec), 32'((cyc - acc[k]) / sp));
            if (done[k]) begin
                done_cnt[k]++;
                if (sbq.size() == 0) begin
                    chk("spurious_done", 32'(1), 32'(0));
                end else begin
                    e = sbq.pop_front();
                    chk("inst", 32'(k), 32'(e.inst));
                    chk("score", 32'(score[k]), 32'(e.score));
                    chk("mask", 32'(mask[k]), 32'(e.mask));
                    chk("pass", 32'(pass[k]), 32'(e.pass));
                    chk("latency", 32'(cyc - acc[k] + 1),
                        32'(16 * sp + 1));
                end
            end
            busy_q[k] = busy[k];
        end
    end

    task automatic run(int k, int m, logic [15:0] t);
        @(negedge clk);
        mode[k]   = m;
        target[k] = t;
        push_exp(k);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic wait_done(int k, int n0);
        bit seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt[k] > n0) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("timeout", 32'(0), 32'(1));
    endtask

    task automatic run_wait(int k, int m, logic [15:0] t);
        int n0;
        n0 = done_cnt[k];
        run(k, m, t);
        wait_done(k, n0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_score"}, 32'(score[0]), 32'(0));
        chk({tag, "_mask"}, 32'(mask[0]), 32'(0));
        chk({tag, "_pass"}, 32'(pass[0]), 32'(0));
        chk({tag, "_busy"}, 32'(busy[0]), 32'(0));
        chk({tag, "_done"}, 32'(done[0]), 32'(0));
        chk({tag, "_abcd"},
            32'({a[0], b[0], c[0], d[0]}), 32'(0));
    endtask

    initial begin
        int  n0;
        bit  found;
        rst_n    = 1'b0;
        start    = '{1'b0, 1'b0};
        target   = '{16'h0, 16'h0};
        mode     = '{0, 0};
        acc      = '{0, 0};
        done_cnt = '{0, 0};
        busy_q   = '{1'b0, 1'b0};
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_start", 32'(busy[0]), 32'(0));

        run_wait(0, 0, 16'hF000);
        run_wait(0, 0, 16'h0000);
        run_wait(0, 1, 16'hAAAA);

        // Start pulse and target change mid-run are ignored.
        n0 = done_cnt[0];
        run(0, 0, 16'hF000);
        repeat (10) @(negedge clk);
        start[0]  = 1'b1;
        target[0] = 16'hFFFF;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, n0);
        repeat (5) @(negedge clk);
        chk("one_done", 32'(done_cnt[0] - n0), 32'(1));

        // Start held high: back-to-back runs via IDLE.
        n0 = done_cnt[0];
        @(negedge clk);
        mode[0]   = 0;
        target[0] = 16'hF000;
        push_exp(0);
        push_exp(0);
        start[0] = 1'b1;
        wait_done(0, n0);
        repeat (3) @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, n0 + 1);
        repeat (5) @(negedge clk);
        chk("held_runs", 32'(done_cnt[0] - n0), 32'(2));

        // Reset in the middle of vector 7.
        run(0, 0, 16'h0000);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (busy[0] && {a[0], b[0], c[0], d[0]} == 4'd7) begin
                found = 1;
                break;
            end
        end
        chk("found_v7", 32'(found), 32'(1));
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        sbq.delete(sbq.size() - 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_after_rst", 32'(busy[0]), 32'(0));
        end
        run_wait(0, 0, 16'h0000);

        // Zero settle cycles, parity circuit.
        run_wait(1, 2, 16'h6996);

        chk("queue_empty", 32'(sbq.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
